// File: rtl/cam_cap_pkg.sv
// Shared camera-capture definitions: FSM states, default QQVGA geometry and the
// ceil-log2 helper used to validate counter widths at elaboration.
package cam_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  localparam int unsigned H_PIX_DEF = 160;
  localparam int unsigned V_PIX_DEF = 120;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned     r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < 64'(v)) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registered rise/fall detector; edges are combinational from d and its previous
// value, so an edge is usable in the cycle it is first seen. No backpressure.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev_q, prev_d;

  always_comb prev_d = d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;
  assign fall = ~d & prev_q;

endmodule

// File: rtl/cam_frame_addr_gen.sv
// Frame-buffer write-address generator: one registered write (1-cycle latency) per
// accepted pixel, no backpressure. LINE_ERR_CNT_EN adds a saturating bad-line counter.
module cam_frame_addr_gen
  import cam_cap_pkg::*;
#(
  parameter int unsigned H_PIX  = H_PIX_DEF,
  parameter int unsigned V_PIX  = V_PIX_DEF,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned COL_W  = 8,
  parameter int unsigned ROW_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              vsync,
  input  logic              href,
  input  logic              px_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic              busy,
  output logic              ok,
  output logic              frame_done,
  output logic              short_frame,
`ifdef LINE_ERR_CNT_EN
  output logic [7:0]        line_err_cnt,
`endif
  output logic              overrun
);

  if (ADDR_W < clog2(H_PIX * V_PIX)) begin : g_chk_addr_w
    $error("ADDR_W too small for H_PIX*V_PIX");
  end
  if (COL_W < clog2(H_PIX + 1)) begin : g_chk_col_w
    $error("COL_W too small for H_PIX");
  end
  if (ROW_W < clog2(V_PIX + 1)) begin : g_chk_row_w
    $error("ROW_W too small for V_PIX");
  end

  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(H_PIX * V_PIX - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(H_PIX - 1);

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [COL_W-1:0]  ccnt_q, ccnt_d, col_q, col_d;
  logic [ROW_W-1:0]  rcnt_q, rcnt_d, row_q, row_d;
  logic              wr_en_q, wr_en_d, short_q, short_d, ovr_q, ovr_d;
  logic              px_acc, vs_rise, vs_fall, hr_rise, hr_fall;
  logic              unused_edges;

  sync_edge_det u_vsync_edge (.clk(clk), .rst(rst), .d(vsync), .rise(vs_rise), .fall(vs_fall));
  sync_edge_det u_href_edge  (.clk(clk), .rst(rst), .d(href),  .rise(hr_rise), .fall(hr_fall));

  assign unused_edges = vs_fall ^ hr_rise ^ hr_fall;
  assign px_acc       = px_valid & href;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ccnt_d  = ccnt_q;
    rcnt_d  = rcnt_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    wr_en_d = 1'b0;
    short_d = short_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          short_d = 1'b0;
          ovr_d   = 1'b0;
        end
      end
      ARM: begin
        if (vs_rise) begin
          state_d = CAPTURE;
          cnt_d   = '0;
          ccnt_d  = '0;
          rcnt_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      CAPTURE: begin
        if (px_acc) begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q;
          col_d   = ccnt_q;
          row_d   = rcnt_q;
          cnt_d   = cnt_q + 1'b1;
          if (ccnt_q == COL_LAST) begin
            ccnt_d = '0;
            rcnt_d = rcnt_q + 1'b1;
          end else begin
            ccnt_d = ccnt_q + 1'b1;
          end
          if (cnt_q == PIX_LAST) state_d = DONE;
        end
        // A vsync edge that coincides with the last pixel still counts as a full frame.
        if (vs_rise && state_d != DONE) begin
          state_d = DONE;
          short_d = 1'b1;
        end
      end
      default: state_d = continuous ? ARM : IDLE;
    endcase
    if (px_acc && state_q != CAPTURE) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ccnt_q  <= '0;
      rcnt_q  <= '0;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wr_en_q <= 1'b0;
      short_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ccnt_q  <= ccnt_d;
      rcnt_q  <= rcnt_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wr_en_q <= wr_en_d;
      short_q <= short_d;
      ovr_q   <= ovr_d;
    end
  end

  assign addr        = addr_q;
  assign col         = col_q;
  assign row         = row_q;
  assign wr_en       = wr_en_q;
  assign short_frame = short_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q == ARM) || (state_q == CAPTURE);
  assign ok          = (state_q == CAPTURE);
  assign frame_done  = (state_q == DONE);

`ifdef LINE_ERR_CNT_EN
  localparam int unsigned LPX_W = COL_W + 1;

  // Per-line pixel count saturates just above H_PIX; only "== H_PIX" matters.
  logic [LPX_W-1:0] lpx_q, lpx_d;
  logic [7:0]       lec_q, lec_d;

  always_comb begin
    lpx_d = lpx_q;
    lec_d = lec_q;
    if (state_q == CAPTURE && hr_fall && lpx_q != LPX_W'(H_PIX) && lec_q != 8'hFF)
      lec_d = lec_q + 8'd1;
    if (hr_fall || (state_q == ARM && vs_rise))
      lpx_d = '0;
    else if (state_q == CAPTURE && px_acc && lpx_q != LPX_W'(H_PIX + 1))
      lpx_d = lpx_q + 1'b1;
    if (state_q == IDLE && start)
      lec_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lpx_q <= '0;
      lec_q <= '0;
    end else begin
      lpx_q <= lpx_d;
      lec_q <= lec_d;
    end
  end

  assign line_err_cnt = lec_q;
`endif

endmodule
